// File: rtl/disp_pkg.sv
// Shared definitions for the multiplexed 7-segment display scanner.
// Holds the scan state encoding and the active-low hex segment table
// (bit order gfedcba, a 0 lights the segment).
package disp_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } scan_state_t;

  // All segments dark.
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Entry 15 first, entry 0 last, so SEG_TABLE[v] is the pattern for v.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex to 7-segment decoder, active-low outputs.
// Ports:
//   value : 4-bit hex digit
//   seg_n : segments gfedcba, 0 = lit
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_TABLE[value];

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scanner for up to four 7-segment digits.
// Each digit is lit for PRESCALE cycles, followed by GAP_CYC cycles with
// every anode off so two digits never overlap.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   en                     : scan enable, low blanks the display
//   wr_en/wr_idx/wr_data/
//   wr_blank               : single-cycle write of one digit register
//   seg_n                  : registered segments gfedcba, active-low
//   an_n                   : registered digit enables, active-low
//   scan_idx               : digit currently addressed by the scan
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 1000,
  parameter int GAP_CYC  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            wr_en,
  input  logic [1:0]      wr_idx,
  input  logic [3:0]      wr_data,
  input  logic            wr_blank,
  output logic [6:0]      seg_n,
  output logic [NDIG-1:0] an_n,
  output logic [1:0]      scan_idx
);

  localparam int PW = $clog2(PRESCALE);
  // A single guard cycle still needs a 1-bit counter.
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYC - 1);
  localparam logic [1:0]    IDX_LAST   = 2'(NDIG - 1);

  scan_state_t          state, state_next;
  logic [PW-1:0]        presc, presc_next;
  logic [GW-1:0]        gap_cnt, gap_next;
  logic [1:0]           idx_next;
  logic [NDIG-1:0][3:0] dig_val;
  logic [NDIG-1:0]      dig_blank;
  logic                 wr_hit;
  logic                 blank_next;
  logic [NDIG-1:0]      an_next;
  logic [3:0]           dec_in;
  logic [6:0]           dec_seg;

  assign wr_hit = wr_en && (int'(wr_idx) < NDIG);

  // Digit registers; writes are independent of the scan so a write on a
  // scan-advance edge is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_val   <= '0;
      dig_blank <= '1;
    end else if (wr_hit) begin
      dig_val[wr_idx]   <= wr_data;
      dig_blank[wr_idx] <= wr_blank;
    end
  end

  // Scan state, prescaler, guard counter and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OFF;
      presc    <= '0;
      gap_cnt  <= '0;
      scan_idx <= '0;
    end else begin
      state    <= state_next;
      presc    <= presc_next;
      gap_cnt  <= gap_next;
      scan_idx <= idx_next;
    end
  end

  // Next-state logic. Dropping en wins over any terminal count.
  // The anode pattern is computed from the next state and the next digit
  // contents (write forwarded) so the an_n register lines up with state.
  always_comb begin
    state_next = state;
    presc_next = presc;
    gap_next   = gap_cnt;
    idx_next   = scan_idx;
    blank_next = 1'b1;
    an_next    = '1;

    if (!en) begin
      state_next = OFF;
      presc_next = '0;
      gap_next   = '0;
      idx_next   = '0;
    end else begin
      case (state)
        OFF: begin
          state_next = SHOW;
          presc_next = '0;
          gap_next   = '0;
          idx_next   = '0;
        end
        SHOW: begin
          if (presc == PRESC_LAST) begin
            state_next = GAP;
            presc_next = '0;
            gap_next   = '0;
          end else begin
            presc_next = presc + PW'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state_next = SHOW;
            gap_next   = '0;
            idx_next   = (scan_idx == IDX_LAST) ? 2'd0 : scan_idx + 2'd1;
          end else begin
            gap_next = gap_cnt + GW'(1);
          end
        end
        default: begin
          state_next = OFF;
          presc_next = '0;
          gap_next   = '0;
          idx_next   = '0;
        end
      endcase
    end

    if (wr_hit && (wr_idx == idx_next)) begin
      blank_next = wr_blank;
    end else begin
      blank_next = dig_blank[idx_next];
    end

    if ((state_next == SHOW) && !blank_next) begin
      an_next = ~(NDIG'(1) << idx_next);
    end
  end

  // One decoder shared by all digits, fed by the addressed digit.
  assign dec_in = dig_val[scan_idx];

  seg7_decode u_dec (
    .value (dec_in),
    .seg_n (dec_seg)
  );

  // Output registers; segments trail the scan state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n  <= '1;
      seg_n <= SEG_OFF;
    end else begin
      an_n  <= an_next;
      seg_n <= ((state == SHOW) && !dig_blank[scan_idx]) ? dec_seg : SEG_OFF;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with NDIG=4, PRESCALE=4,
// GAP_CYC=2. A cycle-position model predicts an_n, seg_n and scan_idx
// every cycle; directed literal checks pin the model's timing.
module tb_display_scan_ctrl;

  localparam int NDIG     = 4;
  localparam int PRESCALE = 4;
  localparam int GAP_CYC  = 2;
  localparam int SLOT     = PRESCALE + GAP_CYC;
  localparam int PERIOD   = NDIG * SLOT;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic            wr_en;
  logic [1:0]      wr_idx;
  logic [3:0]      wr_data;
  logic            wr_blank;
  logic [6:0]      seg_n;
  logic [NDIG-1:0] an_n;
  logic [1:0]      scan_idx;

  int n_cmp  = 0;
  int n_fail = 0;

  display_scan_ctrl #(
    .NDIG     (NDIG),
    .PRESCALE (PRESCALE),
    .GAP_CYC  (GAP_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .wr_blank (wr_blank),
    .seg_n    (seg_n),
    .an_n     (an_n),
    .scan_idx (scan_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Standard active-low hex glyphs, gfedcba.
  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: while enabled, position in the scan is just a cycle count since
  // the first enabled edge; digit and show/guard phase follow by division.
  int         m_val [NDIG];
  bit         m_blank [NDIG];
  bit         m_run;
  int         m_cnt;
  int         m_dig;
  logic [NDIG-1:0] exp_an;
  logic [6:0] exp_seg;
  logic [1:0] exp_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NDIG; i++) begin
        m_val[i]   = 0;
        m_blank[i] = 1'b1;
      end
      m_run   = 1'b0;
      m_cnt   = 0;
      exp_an  = '1;
      exp_seg = 7'h7F;
      exp_idx = 2'd0;
    end else begin
      m_dig = m_cnt / SLOT;
      if (m_run && ((m_cnt % SLOT) < PRESCALE) && !m_blank[m_dig]) begin
        exp_seg = seg_tab[m_val[m_dig]];
      end else begin
        exp_seg = 7'h7F;
      end
      if (wr_en && (int'(wr_idx) < NDIG)) begin
        m_val[wr_idx]   = int'(wr_data);
        m_blank[wr_idx] = wr_blank;
      end
      if (!en) begin
        m_run = 1'b0;
        m_cnt = 0;
      end else if (!m_run) begin
        m_run = 1'b1;
        m_cnt = 0;
      end else begin
        m_cnt = (m_cnt + 1) % PERIOD;
      end
      m_dig   = m_cnt / SLOT;
      exp_idx = m_run ? 2'(m_dig) : 2'd0;
      exp_an  = '1;
      if (m_run && ((m_cnt % SLOT) < PRESCALE) && !m_blank[m_dig]) begin
        exp_an[m_dig] = 1'b0;
      end
    end
  end

  // Compare every cycle, away from the rising edge.
  always @(negedge clk) begin
    check_output("an_n", an_n, exp_an);
    check_output("seg_n", seg_n, exp_seg);
    check_output("scan_idx", scan_idx, exp_idx);
    check_output("an_at_most_one", ($countones(~an_n) <= 1), 1);
  end

  task automatic write_digit(input int idx, input int data, input bit blank);
    @(negedge clk);
    wr_en    = 1'b1;
    wr_idx   = 2'(idx);
    wr_data  = 4'(data);
    wr_blank = blank;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  logic [3:0] an_log  [67];
  logic [6:0] seg_log [67];
  logic [1:0] idx_log [67];

  task automatic apply_stimulus;
    // Reset state
    rst_n = 1'b0; en = 1'b0; wr_en = 1'b0;
    wr_idx = 2'd0; wr_data = 4'd0; wr_blank = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_an", an_n, 4'hF);
    check_output("reset_seg", seg_n, 7'h7F);
    check_output("reset_idx", scan_idx, 2'd0);
    rst_n = 1'b1;

    // Scanning with every digit still blank keeps the display dark.
    en = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check_output("blank_scan_an", an_n, 4'hF);
      check_output("blank_scan_seg", seg_n, 7'h7F);
    end

    en = 1'b0;
    @(negedge clk);
    write_digit(0, 1, 1'b0);
    write_digit(1, 2, 1'b0);
    write_digit(2, 3, 1'b0);
    write_digit(3, 15, 1'b0);

    // Run the scan, with a live write to digit 2 and an en drop on digit 1.
    en = 1'b1;
    for (int k = 0; k < 67; k++) begin
      @(negedge clk);
      an_log[k]  = an_n;
      seg_log[k] = seg_n;
      idx_log[k] = scan_idx;
      if (k == 36) begin
        wr_en = 1'b1; wr_idx = 2'd2; wr_data = 4'h8; wr_blank = 1'b0;
      end
      if (k == 37) wr_en = 1'b0;
      if (k == 55) en = 1'b0;
      if (k == 58) en = 1'b1;
    end

    check_output("k0_an", an_log[0], 4'b1110);
    check_output("k0_seg", seg_log[0], 7'b1111111);
    check_output("k1_seg", seg_log[1], 7'b1111001);
    check_output("k4_gap_an", an_log[4], 4'b1111);
    check_output("k4_seg", seg_log[4], 7'b1111001);
    check_output("k5_gap_seg", seg_log[5], 7'b1111111);
    check_output("k6_an", an_log[6], 4'b1101);
    check_output("k7_seg", seg_log[7], 7'b0100100);
    check_output("k13_an", an_log[13], 4'b1011);
    check_output("k13_seg", seg_log[13], 7'b0110000);
    check_output("k19_an", an_log[19], 4'b0111);
    check_output("k19_seg", seg_log[19], 7'b0001110);
    check_output("k24_period_an", an_log[24], 4'b1110);
    check_output("k24_idx", idx_log[24], 2'd0);
    check_output("wr_edge_seg", seg_log[37], 7'b0110000);
    check_output("wr_plus1_seg", seg_log[38], 7'b0000000);
    check_output("k43_seg", seg_log[43], 7'b0001110);
    check_output("k49_seg", seg_log[49], 7'b1111001);
    check_output("en_drop_an", an_log[56], 4'b1111);
    check_output("en_drop_idx", idx_log[56], 2'd0);
    check_output("en_drop_seg", seg_log[57], 7'b1111111);
    check_output("restart_an", an_log[59], 4'b1110);
    check_output("restart_idx", idx_log[59], 2'd0);
    check_output("restart_seg", seg_log[60], 7'b1111001);

    // Asynchronous reset between clock edges while digit 1 is lit.
    @(posedge clk);
    #1;
    check_output("pre_rst_an", an_n, 4'b1101);
    check_output("pre_rst_seg", seg_n, 7'b0100100);
    #1 rst_n = 1'b0;
    #1;
    check_output("async_rst_an", an_n, 4'hF);
    check_output("async_rst_seg", seg_n, 7'h7F);
    check_output("async_rst_idx", scan_idx, 2'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check_output("post_rst_blank_an", an_n, 4'hF);
      check_output("post_rst_blank_seg", seg_n, 7'h7F);
    end

    // Mixed writes and occasional en drops, checked by the model.
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_idx   = 2'($urandom_range(0, 3));
      wr_data  = 4'($urandom_range(0, 15));
      wr_blank = ($urandom_range(0, 3) == 0);
      en       = ($urandom_range(0, 29) != 0);
    end
    @(negedge clk);
    wr_en = 1'b0;
    en    = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    apply_stimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL provide parameter NDIG, default 4: number of multiplexed digits, range 2..4.
REQ-002 SHALL provide parameter PRESCALE, default 1000: clk cycles each digit is shown, minimum 2.
REQ-003 SHALL provide parameter GAP_CYC, default 4: all-off guard cycles between digits, minimum 1.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  scan enable; low turns the display off.
REQ-007 SHALL have port wr_en  input  1  write strobe for one digit register, single cycle.
REQ-008 SHALL have port wr_idx  input  2  target digit of the write.
REQ-009 SHALL have port wr_data  input  4  hex value 0x0..0xF to store.
REQ-010 SHALL have port wr_blank  input  1  blank flag stored with wr_data.
REQ-011 SHALL have port seg_n  output  7  segments, active-low, bit order gfedcba, registered.
REQ-012 SHALL have port an_n  output  NDIG  digit enables, active-low, registered, at most one low.
REQ-013 SHALL have port scan_idx  output  2  digit currently addressed by the scan.

Function
REQ-014 SHALL hold NDIG digit registers, each 4-bit value plus blank flag.
REQ-015 SHALL load wr_data/wr_blank into digit wr_idx on the edge where wr_en=1; wr_idx>=NDIG is ignored.
REQ-016 SHALL run FSM states OFF, SHOW, GAP.
REQ-017 OFF: an_n all ones, seg_n 1111111, prescaler 0, scan_idx 0; en=1 -> SHOW next edge.
REQ-018 SHOW: prescaler counts 0..PRESCALE-1; at PRESCALE-1 -> GAP, prescaler cleared.
REQ-019 GAP: an_n all ones for exactly GAP_CYC cycles; on the last cycle scan_idx advances, wrapping NDIG-1 -> 0, then -> SHOW.
REQ-020 en=0 in any state SHALL force OFF on the next edge; en has priority over prescaler terminal count.
REQ-021 In SHOW, an_n[scan_idx] SHALL be 0 unless that digit's blank flag is 1, in which case an_n is all ones.
REQ-022 seg_n SHALL equal the decode of the addressed digit's value, registered one cycle after state/scan_idx; blanked or non-SHOW -> 1111111.
REQ-023 Decode SHALL be the standard active-low hex table: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110, all 16 codes defined.
REQ-024 A write to the digit being shown SHALL appear on seg_n two edges after the write edge (register, then output register); a write on the same edge as a scan advance SHALL take effect with no lost update.
REQ-025 an_n SHALL never assert two digits in the same cycle, including across SHOW->GAP->SHOW and en toggling.
REQ-026 Full scan period SHALL be NDIG*(PRESCALE+GAP_CYC) cycles while en=1.

Reset
REQ-027 On rst_n=0, SHALL asynchronously enter OFF: an_n all ones, seg_n 1111111, scan_idx 0, prescaler 0.
REQ-028 On reset, all digit registers SHALL be value 0, blank 1.
REQ-029 Reset mid-scan SHALL drop the display immediately; after release, SHOW starts at digit 0 on the first edge with en=1.

Structure
REQ-030 SHALL place the state enum (OFF/SHOW/GAP) and the 16-entry segment table constants in shared package disp_pkg.
REQ-031 SHALL instantiate one combinational sub-module seg7_decode (4-bit in, 7-bit active-low out), time-shared across all digits.
REQ-032 Prescaler and GAP counters SHALL be sized by $clog2 of their parameters; no other sub-modules.

Verification
REQ-033 Reset then en=1, no writes, PRESCALE=4, GAP_CYC=2 -> an_n stays all ones, seg_n=1111111 for 50 cycles.
REQ-034 Write digits 0..3 = 1,2,3,F unblanked, en=1 -> an_n walks 1110,1101,1011,0111 with seg_n 1111001, 0100100, 0110000, 0001110; 2 all-off cycles between; period 24 cycles.
REQ-035 Write 8 to digit 2 while digit 2 is shown -> seg_n=0000000 exactly two edges after the write edge; no other digit changes.
REQ-036 Drop en mid-SHOW on digit 1 -> next edge OFF, an_n 1111; reassert -> scan restarts at digit 0.
REQ-037 Assert rst_n=0 between clock edges mid-scan -> an_n 1111, seg_n 1111111 without waiting for clk; digits read back blank.
REQ-038 Throughout all scenarios, assertion checks an_n has at most one zero bit every cycle.
